// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed 4-digit seven-segment bus and rebuilds a 16-bit BCD frame
module seg7_scan_decoder #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic [3:0]  sel,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        err
);
  localparam logic [7:0] LP_SETTLE = 8'(SETTLE);
  logic [6:0]  w_seg;
  logic        w_onehot;
  logic        w_same;
  logic [7:0]  w_run_next;
  logic        w_cap;
  logic [3:0]  w_nib;
  logic        w_inv;
  logic [1:0]  w_idx;
  logic [3:0]  w_seen_next;
  logic        w_done;
  logic [15:0] w_slot_next;
  logic [3:0]  r_sel;
  logic [6:0]  r_seg;
  logic [7:0]  r_run;
  logic [15:0] r_slot;
  logic [3:0]  r_seen;
  logic        r_sticky;
  assign w_seg       = {a, b, c, d, e, f, g};
  assign w_onehot    = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign w_same      = (r_run != 8'd0) && (sel == r_sel) && (w_seg == r_seg);
  assign w_run_next  = !w_onehot ? 8'd0 : !w_same ? 8'd1 : (r_run == LP_SETTLE) ? LP_SETTLE : r_run + 8'd1;
  // a saturated, unchanged combo must not capture again
  assign w_cap       = (w_run_next == LP_SETTLE) && !(w_same && (r_run == LP_SETTLE));
  assign w_idx       = sel[0] ? 2'd0 : sel[1] ? 2'd1 : sel[2] ? 2'd2 : 2'd3;
  assign w_seen_next = r_seen | sel;
  assign w_done      = w_cap && (w_seen_next == 4'hF);
  // segment pattern to BCD; unknown patterns map to F and flag invalid
  always_comb begin
    w_inv = 1'b0;
    case (w_seg)
      7'b1111110: w_nib = 4'd0;
      7'b0110000: w_nib = 4'd1;
      7'b1101101: w_nib = 4'd2;
      7'b1111001: w_nib = 4'd3;
      7'b0110011: w_nib = 4'd4;
      7'b1011011: w_nib = 4'd5;
      7'b1011111: w_nib = 4'd6;
      7'b1110000: w_nib = 4'd7;
      7'b1111111: w_nib = 4'd8;
      7'b1111011: w_nib = 4'd9;
      default: begin
        w_nib = 4'hF;
        w_inv = 1'b1;
      end
    endcase
  end
  // slot image including the nibble being captured this edge
  always_comb begin
    w_slot_next = r_slot;
    w_slot_next[w_idx*4 +: 4] = w_nib;
  end
  // run-length history of the sampled (sel, segment) combo
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= 4'd0;
      r_seg <= 7'd0;
      r_run <= 8'd0;
    end else begin
      r_sel <= sel;
      r_seg <= w_seg;
      r_run <= w_run_next;
    end
  end
  // frame assembly and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot   <= 16'd0;
      r_seen   <= 4'd0;
      r_sticky <= 1'b0;
      bcd      <= 16'd0;
      err      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= w_done;
      if (w_cap) begin
        r_slot <= w_slot_next;
        if (w_done) begin
          r_seen   <= 4'd0;
          r_sticky <= 1'b0;
          bcd      <= w_slot_next;
          err      <= r_sticky | w_inv;
        end else begin
          r_seen   <= w_seen_next;
          r_sticky <= r_sticky | w_inv;
        end
      end
    end
  end
endmodule
